program_loader: RTL and testbench



---
 rtl/program_loader.sv | 125 ++++++++++++
 tb/tb_program_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: assembles big-endian 32-bit words from a UART byte stream
// and writes them into instruction memory at incrementing byte addresses.
// Loading ends after the halt word is written or the memory is full;
// o_done then stays high until reset.
//
// state | meaning
// IDLE  | waiting for i_enable; received bytes are ignored
// LOAD  | assembling bytes into words and issuing write strobes
// DONE  | load finished; absorbing until reset
module program_loader #(
    parameter int          MEM_DEPTH = 64,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_done,
    output logic        o_write,
    output logic [31:0] o_address,
    output logic [31:0] o_instruction,
    output logic [31:0] o_word_count,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] LAST_IDX = 32'(MEM_DEPTH - 1);

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] instr_q, instr_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        end_load;

    // Next-state logic: byte assembly, write strobe generation and end-of-load detection.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        instr_d    = instr_q;
        write_d    = 1'b0;
        addr_d     = addr_q;
        count_d    = count_q;
        end_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // The write cycle ends here; the word in flight decides whether loading stops.
                if (write_q) begin
                    addr_d  = addr_q + 32'd4;
                    count_d = count_q + 32'd1;
                    if ((instr_q == HALT_WORD) || (count_q == LAST_IDX)) begin
                        state_d  = DONE;
                        end_load = 1'b1;
                    end
                end
                // A byte arriving during a terminating write is dropped; otherwise it starts the next word.
                if (i_rx_done && !end_load) begin
                    if (byte_cnt_q == 2'd3) begin
                        instr_d = {asm_q, i_rx_data};
                        write_d = 1'b1;
                    end else begin
                        asm_d = {asm_q[15:0], i_rx_data};
                    end
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = DONE;
            end
        endcase

        busy_d = (state_d == LOAD);
        done_d = (state_d == DONE);
    end

    // State and output registers with asynchronous reset clearing any partial word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            instr_q    <= 32'd0;
            write_q    <= 1'b0;
            addr_q     <= 32'd0;
            count_q    <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            instr_q    <= instr_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_write       = write_q;
    assign o_address     = addr_q;
    assign o_instruction = instr_q;
    assign o_word_count  = count_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader (MEM_DEPTH = 4 so memory-full is reachable).
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_done = 1'b0;
    logic        o_write;
    logic [31:0] o_address, o_instruction, o_word_count;
    logic        o_busy, o_done;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } wr_t;

    wr_t exp_q[$];
    int  wr_cyc[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    program_loader #(.MEM_DEPTH(4), .HALT_WORD(32'hFFFFFFFF)) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_enable(enable),
        .i_rx_data(rx_data),
        .i_rx_done(rx_done),
        .o_write(o_write),
        .o_address(o_address),
        .o_instruction(o_instruction),
        .o_word_count(o_word_count),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is popped against the scoreboard.
    always @(negedge clk) begin
        if (o_write === 1'b1) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h instr %h expected no write", o_address, o_instruction);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", o_address, e.addr);
                check("write_instr", o_instruction, e.instr);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] w);
        wr_t e;
        e.addr  = a;
        e.instr = w;
        exp_q.push_back(e);
    endtask

    task automatic start();
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_write"}, {31'd0, o_write}, 32'd0);
        check({tag, "_addr"}, o_address, 32'd0);
        check({tag, "_instr"}, o_instruction, 32'd0);
        check({tag, "_count"}, o_word_count, 32'd0);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, o_done}, 32'd0);
    endtask

    task automatic wait_drained();
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check_zero("reset");
        do_reset();

        // Gating: bytes in IDLE and in the enable cycle are ignored.
        send_byte(8'h11);
        send_byte(8'h22);
        check("idle_busy", {31'd0, o_busy}, 32'd0);
        enable  = 1'b1;
        rx_data = 8'h99;
        rx_done = 1'b1;
        tick(1);
        enable  = 1'b0;
        rx_done = 1'b0;
        check("enter_busy", {31'd0, o_busy}, 32'd1);

        // Basic word.
        expect_write(32'd0, 32'h20010005);
        send_word(32'h20010005);
        check("basic_latency", {31'd0, o_write}, 32'd1);
        tick(1);
        check("basic_pulse_end", {31'd0, o_write}, 32'd0);
        check("basic_count", o_word_count, 32'd1);
        check("basic_addr", o_address, 32'd4);
        check("basic_instr_hold", o_instruction, 32'h20010005);
        check("basic_still_busy", {31'd0, o_busy}, 32'd1);
        wait_drained();

        // Two words at full rate.
        do_reset();
        start();
        wr_cyc.delete();
        expect_write(32'd0, 32'h8C220004);
        expect_write(32'd4, 32'hAC220008);
        send_word(32'h8C220004);
        send_word(32'hAC220008);
        tick(1);
        wait_drained();
        check("fullrate_count", o_word_count, 32'd2);
        check("fullrate_addr", o_address, 32'd8);
        check("fullrate_nwrites", wr_cyc.size(), 32'd2);
        if (wr_cyc.size() == 2) check("fullrate_spacing", wr_cyc[1] - wr_cyc[0], 32'd4);

        // Halt word, plus a byte during the terminating write that must be dropped.
        do_reset();
        start();
        expect_write(32'd0, 32'h01020304);
        expect_write(32'd4, 32'hFFFFFFFF);
        send_word(32'h01020304);
        send_word(32'hFFFFFFFF);
        send_byte(8'h55);
        check("halt_done", {31'd0, o_done}, 32'd1);
        check("halt_busy", {31'd0, o_busy}, 32'd0);
        check("halt_count", o_word_count, 32'd2);
        check("halt_addr", o_address, 32'd8);
        start();
        send_word(32'h12345678);
        tick(2);
        check("done_absorbing", {31'd0, o_done}, 32'd1);
        check("done_count_hold", o_word_count, 32'd2);
        check("done_instr_hold", o_instruction, 32'hFFFFFFFF);
        wait_drained();

        // Memory full with MEM_DEPTH = 4.
        do_reset();
        start();
        for (int i = 0; i < 4; i++) begin
            expect_write(32'(4 * i), 32'h0A0B0C00 + 32'(i));
            send_word(32'h0A0B0C00 + 32'(i));
        end
        tick(1);
        check("full_done", {31'd0, o_done}, 32'd1);
        check("full_addr", o_address, 32'd16);
        check("full_count", o_word_count, 32'd4);
        send_word(32'h0A0B0C04);
        tick(2);
        check("full_fifth_ignored", o_word_count, 32'd4);
        wait_drained();

        // Reset mid-word.
        do_reset();
        start();
        send_byte(8'hDE);
        send_byte(8'hAD);
        reset = 1'b1;
        #2;
        check_zero("midword");
        tick(1);
        reset = 1'b0;
        send_word(32'h33333333);
        tick(1);
        check("after_reset_idle", {31'd0, o_busy}, 32'd0);
        start();
        expect_write(32'd0, 32'hCAFE0001);
        send_word(32'hCAFE0001);
        tick(1);
        check("fresh_count", o_word_count, 32'd1);
        wait_drained();

        // Reset during the write cycle suppresses the pending strobe.
        do_reset();
        start();
        send_word(32'h44444444);
        reset = 1'b1;
        #2;
        check_zero("midwrite");
        tick(1);
        reset = 1'b0;
        tick(3);
        wait_drained();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
